// File: rtl/ddr_line_responder_if.sv
// ---------------------------------------------------------------------------
// ddr_line_responder_if
//   Cache-line bus between the data cache (master) and a line responder
//   (slave): 128-bit writebacks, line-fill address requests and fill data.
//
// Signals:
//   wr_addr/wr_data/wr_valid  writeback request       (master -> slave)
//   wr_ready                  slave idle, write accept (slave -> master)
//   rd_addr/rd_avalid         fill address request     (master -> slave)
//   rd_aready                 fill address accept      (slave -> master)
//   rd_data/rd_valid          fill data                (slave -> master)
//   rd_dready                 cache accepts fill data  (master -> slave)
// ---------------------------------------------------------------------------
interface ddr_line_responder_if #(
  parameter int ADDR_W = 27,
  parameter int LINE_W = 128
);
  logic [ADDR_W-1:0] wr_addr;
  logic [LINE_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_avalid;
  logic              rd_aready;
  logic [LINE_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_dready;

  modport master (
    output wr_addr, wr_data, wr_valid, rd_addr, rd_avalid, rd_dready,
    input  wr_ready, rd_aready, rd_data, rd_valid
  );

  modport slave (
    input  wr_addr, wr_data, wr_valid, rd_addr, rd_avalid, rd_dready,
    output wr_ready, rd_aready, rd_data, rd_valid
  );
endinterface

// File: rtl/ddr_line_responder.sv
// ---------------------------------------------------------------------------
// ddr_line_responder
//   Responder end of the data-cache line interface. Stores lines in an
//   on-chip array with configurable write-commit and read-capture latency,
//   standing in for the DDR controller in simulation and DDR-less builds.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous reset, active low (0 = reset)
//   bus  ddr_line_responder_if.slave (write / fill-address / fill-data)
//
// Line index is addr[4 +: DEPTH_LOG2]; the byte offset and the bits above the
// index are ignored, so addresses alias modulo the array depth.
// ---------------------------------------------------------------------------
module ddr_line_responder #(
  parameter int ADDR_W     = 27,
  parameter int LINE_W     = 128,
  parameter int DEPTH_LOG2 = 12,
  parameter int WR_LATENCY = 4,
  parameter int RD_LATENCY = 4
) (
  input logic                 clk,
  input logic                 rst,
  ddr_line_responder_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int WCW   = $clog2(WR_LATENCY + 1);
  localparam int RCW   = $clog2(RD_LATENCY + 1);
  localparam logic [WCW-1:0] WR_LAST = WCW'(WR_LATENCY - 1);
  localparam logic [RCW-1:0] RD_LAST = RCW'(RD_LATENCY - 1);

  typedef enum logic {W_IDLE, W_BUSY} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;

  // Line store: zero at configuration, never cleared by reset.
  logic [LINE_W-1:0] r_mem [DEPTH] = '{default: '0};

  // Write side
  wr_state_t             r_wr_state, w_wr_state_next;
  logic [WCW-1:0]        r_wr_cnt, w_wr_cnt_next;
  logic [DEPTH_LOG2-1:0] r_wr_idx;
  logic [LINE_W-1:0]     r_wr_data;
  logic                  w_wr_accept;
  logic                  w_commit;

  // Read side
  rd_state_t             r_rd_state, w_rd_state_next;
  logic [RCW-1:0]        r_rd_cnt, w_rd_cnt_next;
  logic [DEPTH_LOG2-1:0] r_rd_idx;
  logic [LINE_W-1:0]     r_rd_data;
  logic                  w_rd_accept;
  logic                  w_capture;
  logic                  w_hazard;

  // Byte offset and upper address bits have no function here.
  logic w_unused_addr_bits;
  assign w_unused_addr_bits = ^{bus.wr_addr[3:0], bus.rd_addr[3:0],
                                bus.wr_addr >> (4 + DEPTH_LOG2),
                                bus.rd_addr >> (4 + DEPTH_LOG2)};

  // -------------------------------------------------------------------------
  // Write FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_state <= W_IDLE;
      r_wr_cnt   <= '0;
    end else begin
      r_wr_state <= w_wr_state_next;
      r_wr_cnt   <= w_wr_cnt_next;
    end
  end

  always_comb begin
    w_wr_state_next = r_wr_state;
    w_wr_cnt_next   = r_wr_cnt;
    w_wr_accept     = 1'b0;
    w_commit        = 1'b0;
    unique case (r_wr_state)
      W_IDLE: begin
        if (bus.wr_valid && rst) begin
          w_wr_accept     = 1'b1;
          w_wr_cnt_next   = '0;
          w_wr_state_next = W_BUSY;
        end
      end
      W_BUSY: begin
        // Commit lands on the last busy cycle; gating with rst drops an
        // in-flight write when reset arrives.
        if (r_wr_cnt == WR_LAST) begin
          w_commit        = rst;
          w_wr_state_next = W_IDLE;
        end else begin
          w_wr_cnt_next = r_wr_cnt + WCW'(1);
        end
      end
      default: w_wr_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr_accept) begin
      r_wr_idx  <= bus.wr_addr[4 +: DEPTH_LOG2];
      r_wr_data <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_mem[r_wr_idx] <= r_wr_data;
    end
  end

  // -------------------------------------------------------------------------
  // Read FSM
  // -------------------------------------------------------------------------
  // A read must not capture a line that a busy write is about to replace;
  // holding off until the write leaves W_BUSY returns the new data.
  assign w_hazard = (r_wr_state == W_BUSY) && (r_wr_idx == r_rd_idx);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_state <= R_IDLE;
      r_rd_cnt   <= '0;
    end else begin
      r_rd_state <= w_rd_state_next;
      r_rd_cnt   <= w_rd_cnt_next;
    end
  end

  always_comb begin
    w_rd_state_next = r_rd_state;
    w_rd_cnt_next   = r_rd_cnt;
    w_rd_accept     = 1'b0;
    w_capture       = 1'b0;
    unique case (r_rd_state)
      R_IDLE: begin
        if (bus.rd_avalid && rst) begin
          w_rd_accept     = 1'b1;
          w_rd_cnt_next   = '0;
          w_rd_state_next = R_WAIT;
        end
      end
      R_WAIT: begin
        // Counter parks at its last value while a hazard stalls capture.
        if (r_rd_cnt == RD_LAST) begin
          if (!w_hazard) begin
            w_capture       = 1'b1;
            w_rd_state_next = R_RESP;
          end
        end else begin
          w_rd_cnt_next = r_rd_cnt + RCW'(1);
        end
      end
      R_RESP: begin
        if (bus.rd_dready) begin
          w_rd_state_next = R_IDLE;
        end
      end
      default: w_rd_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_rd_accept) begin
      r_rd_idx <= bus.rd_addr[4 +: DEPTH_LOG2];
    end
  end

  // Registered array read with enable: rd_data only changes on capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_data <= '0;
    end else if (w_capture) begin
      r_rd_data <= r_mem[r_rd_idx];
    end
  end

  // Outputs take their reset values as soon as rst is low, not one edge later.
  assign bus.wr_ready  = !rst || (r_wr_state == W_IDLE);
  assign bus.rd_aready = !rst || (r_rd_state == R_IDLE);
  assign bus.rd_valid  = rst && (r_rd_state == R_RESP);
  assign bus.rd_data   = rst ? r_rd_data : '0;

endmodule

// File: tb/tb_ddr_line_responder.sv
module tb_ddr_line_responder;
  localparam int ADDR_W     = 27;
  localparam int LINE_W     = 128;
  localparam int DEPTH_LOG2 = 12;
  localparam int WL         = 4;
  localparam int RL         = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ddr_line_responder_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus();

  ddr_line_responder #(
    .ADDR_W(ADDR_W), .LINE_W(LINE_W), .DEPTH_LOG2(DEPTH_LOG2),
    .WR_LATENCY(WL), .RD_LATENCY(RL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference store: line index -> contents; absent entries read as zero.
  logic [LINE_W-1:0] model_mem [int];

  task automatic check(input string tag, input logic [LINE_W-1:0] obs,
                       input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [ADDR_W-1:0] a);
    return int'(a >> 4) % (1 << DEPTH_LOG2);
  endfunction

  function automatic logic [LINE_W-1:0] mem_of(input int i);
    return model_mem.exists(i) ? model_mem[i] : '0;
  endfunction

  function automatic logic [LINE_W-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One transaction: optional write accepted in cycle 0, optional read
  // accepted in cycle rd_off, fill data held back for `hold` cycles.
  // Expected timing follows directly from the latency rules:
  //   write busy cycles 1..WL, commit at end of WL;
  //   read capture at rd_off+RL, pushed to WL+1 if that lands inside the
  //   busy window of a write to the same line; rd_valid from capture+1.
  task automatic xact(input bit do_wr, input logic [ADDR_W-1:0] waddr,
                      input logic [LINE_W-1:0] wdata, input bit do_rd,
                      input logic [ADDR_W-1:0] raddr, input int rd_off,
                      input int hold);
    int c, hs, last, widx, ridx;
    logic [LINE_W-1:0] exp_rd;
    bit exp_wrdy, exp_ardy, exp_val;
    widx = idx_of(waddr);
    ridx = idx_of(raddr);
    c = rd_off + RL;
    if (do_wr && do_rd && widx == ridx && c >= 1 && c <= WL) c = WL + 1;
    exp_rd = (do_wr && widx == ridx && WL < c) ? wdata : mem_of(ridx);
    hs = do_rd ? c + 1 + hold : -1;
    last = do_wr ? WL : 0;
    if (hs > last) last = hs;
    last++;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      bus.wr_valid  = 1'b0;
      bus.rd_avalid = 1'b0;
      bus.rd_dready = 1'($urandom % 2);
      if (do_wr && k == 0) begin
        bus.wr_valid = 1'b1;
        bus.wr_addr  = waddr;
        bus.wr_data  = wdata;
      end else if (do_wr && k <= WL) begin
        // Ignored while wr_ready is low.
        bus.wr_valid = 1'($urandom % 2);
        bus.wr_addr  = ADDR_W'($urandom);
        bus.wr_data  = rand_line();
      end
      if (do_rd && k == rd_off) begin
        bus.rd_avalid = 1'b1;
        bus.rd_addr   = raddr;
      end else if (do_rd && k > rd_off && k <= hs) begin
        bus.rd_avalid = 1'($urandom % 2);
        bus.rd_addr   = ADDR_W'($urandom);
      end
      if (do_rd && k >= c + 1 && k <= hs) bus.rd_dready = (k >= c + 1 + hold);
      #1;
      exp_wrdy = !(do_wr && k >= 1 && k <= WL);
      exp_ardy = !(do_rd && k > rd_off && k <= hs);
      exp_val  = do_rd && k >= c + 1 && k <= hs;
      check("wr_ready", LINE_W'(bus.wr_ready), LINE_W'(exp_wrdy));
      check("rd_aready", LINE_W'(bus.rd_aready), LINE_W'(exp_ardy));
      check("rd_valid", LINE_W'(bus.rd_valid), LINE_W'(exp_val));
      if (exp_val) check("rd_data", bus.rd_data, exp_rd);
    end
    if (do_wr) model_mem[widx] = wdata;
    $display("xact wr=%0d waddr=%h rd=%0d raddr=%h rd_off=%0d hold=%0d fill=%h",
             do_wr, waddr, do_rd, raddr, rd_off, hold, exp_rd);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".wr_ready"}, LINE_W'(bus.wr_ready), LINE_W'(1'b1));
    check({tag, ".rd_aready"}, LINE_W'(bus.rd_aready), LINE_W'(1'b1));
    check({tag, ".rd_valid"}, LINE_W'(bus.rd_valid), LINE_W'(1'b0));
    check({tag, ".rd_data"}, bus.rd_data, '0);
  endtask

  initial begin
    logic [LINE_W-1:0] d_plan, d_aa, d_old, d_new;
    logic [ADDR_W-1:0] a;
    bit dw, dr;

    d_plan = 128'h0123456789ABCDEF0123456789ABCDEF;
    d_aa   = {16{8'hAA}};

    bus.wr_valid  = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.rd_avalid = 1'b0;
    bus.rd_addr   = '0;
    bus.rd_dready = 1'b0;

    // Power-on reset; valids asserted to show nothing is accepted.
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.wr_valid  = 1'b1;
      bus.rd_avalid = 1'b1;
      #1;
      check_reset_outputs("por");
    end
    @(negedge clk);
    bus.wr_valid  = 1'b0;
    bus.rd_avalid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("por_release");

    // Directed plan items.
    xact(1, 27'h0000010, d_plan, 0, '0, 0, 0);
    xact(0, '0, '0, 1, 27'h0000010, 0, 0);
    xact(0, '0, '0, 1, 27'h0000A30, 0, 0);
    xact(0, '0, '0, 1, 27'h000001C, 0, 0);
    xact(1, 27'h0000040, d_aa, 1, 27'h0000040, 0, 0);
    xact(1, 27'h0000040, rand_line(), 1, 27'h0000050, 0, 1);
    xact(0, '0, '0, 1, 27'h0000010, 0, 6);
    xact(1, 27'h0010000, rand_line(), 1, 27'h0000000, 5, 0);
    xact(0, '0, '0, 1, 27'h0000000, 0, 0);

    // Reset in the middle of a write and a read to the same line.
    d_old = rand_line();
    d_new = rand_line();
    xact(1, 27'h0000020, d_old, 0, '0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus.wr_valid  = (k == 0);
      bus.rd_avalid = (k == 0);
      bus.wr_addr   = 27'h0000020;
      bus.wr_data   = d_new;
      bus.rd_addr   = 27'h0000020;
      bus.rd_dready = 1'b1;
      rst = !(k == 2 || k == 3);
      #1;
      if (k == 1) begin
        check("midrst.wr_busy", LINE_W'(bus.wr_ready), LINE_W'(1'b0));
        check("midrst.rd_busy", LINE_W'(bus.rd_aready), LINE_W'(1'b0));
      end else if (k == 2 || k == 3) begin
        check_reset_outputs("midrst");
      end else if (k >= 4) begin
        check("midrst_after.wr_ready", LINE_W'(bus.wr_ready), LINE_W'(1'b1));
        check("midrst_after.rd_aready", LINE_W'(bus.rd_aready), LINE_W'(1'b1));
        check("midrst_after.rd_valid", LINE_W'(bus.rd_valid), LINE_W'(1'b0));
      end
    end
    $display("xact mid-operation reset on line 0x20 done");
    xact(0, '0, '0, 1, 27'h0000020, 0, 0);

    // Randomised traffic over a few lines to provoke hazards and aliasing.
    for (int n = 0; n < 40; n++) begin
      dw = 1'($urandom % 2);
      dr = dw ? 1'($urandom % 2) : 1'b1;
      a = ADDR_W'($urandom);
      a[4 +: DEPTH_LOG2] = DEPTH_LOG2'($urandom_range(0, 3));
      if (dr && dw && ($urandom % 2 == 1)) begin
        xact(dw, a, rand_line(), dr, a ^ 27'h7FF000F, 0, $urandom_range(0, 3));
      end else begin
        logic [ADDR_W-1:0] ra;
        ra = ADDR_W'($urandom);
        ra[4 +: DEPTH_LOG2] = DEPTH_LOG2'($urandom_range(0, 3));
        xact(dw, a, rand_line(), dr, ra, $urandom_range(0, 6), $urandom_range(0, 3));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ddr_line_responder.md
Name: ddr_line_responder

Overview:
- Responder end of the cache-line interface the data cache uses toward ddr_master: accepts 128-bit line writebacks and line-fill reads, and returns fill data.
- Backed by an on-chip line array with parameterised access latency.
- Drop-in replacement for ddr_master in simulation and in DDR-less FPGA builds.
- Same port names and handshake semantics as ddr_master's cache-side ports.

Parameters:
ADDR_W, 27, byte address width of wr_addr/rd_addr
LINE_W, 128, line width in bits (16 bytes)
DEPTH_LOG2, 12, log2 of number of lines stored
WR_LATENCY, 4, cycles from write acceptance to array commit (>=1)
RD_LATENCY, 4, cycles from read-address acceptance to data capture (>=1)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset; synchronous, active-low (0 = reset)
wr_addr  in  ADDR_W  writeback line byte address
wr_data  in  LINE_W  writeback line data
wr_valid  in  1  writeback request
wr_ready  out  1  high = idle, can accept a write; low while a write is in flight
rd_addr  in  ADDR_W  fill line byte address
rd_avalid  in  1  fill address valid
rd_aready  out  1  high = can accept a fill address
rd_data  out  LINE_W  fill data
rd_valid  out  1  fill data valid
rd_dready  in  1  cache ready for fill data

Behaviour:
- Line index = addr[4 +: DEPTH_LOG2]. Bits [3:0] are ignored. Higher bits are ignored, so addresses alias modulo depth.
- Array is zero-initialised at configuration. Reset does not clear it.
- Reset (rst==0):
  - wr_ready=1, rd_aready=1, rd_valid=0, rd_data=0.
  - Both FSMs go idle, counters clear, an in-flight write is dropped without committing.
  - No handshake is accepted while rst==0.
- Write FSM, W_IDLE / W_BUSY:
  - W_IDLE: wr_ready=1. wr_valid in cycle T latches index and data, then goes to W_BUSY.
  - W_BUSY: wr_ready=0 for cycles T+1..T+WR_LATENCY. The array commits at the end of cycle T+WR_LATENCY, then returns to W_IDLE, so wr_ready=1 in T+WR_LATENCY+1.
- Read FSM, R_IDLE / R_WAIT / R_RESP:
  - R_IDLE: rd_aready=1. rd_avalid in cycle T latches index, then goes to R_WAIT; rd_aready=0 until return to R_IDLE.
  - R_WAIT: counts RD_LATENCY cycles, then captures the array line into rd_data and goes to R_RESP. rd_valid=1 first in cycle T+RD_LATENCY+1 when no hazard.
  - R_RESP: rd_valid=1 and rd_data held stable until rd_valid&&rd_dready. Then returns to R_IDLE with rd_valid=0 and rd_aready=1 the next cycle.
- The two FSMs run independently and concurrently; the cache issues writeback and fill in the same cycle.
- Hazard (read returns post-write data):
  - If the read count expires while the write FSM is in W_BUSY with the same index, the read stays in R_WAIT until the write commits.
  - It then captures the new data; rd_valid is delayed accordingly.
  - A commit and a capture of the same index in the same cycle is not allowed. A different index proceeds without delay.
- Simultaneous write and read handshake in the same cycle: both are accepted, and the hazard rule orders them.
- A second request during busy is impossible, since ready is low. Inputs are ignored while ready is low.
- Mid-operation reset: a pending read is dropped and a pending write does not commit.

Test Plan:
- Write addr 0x0000010, data 0x0123...CDEF (WR_LATENCY=4) -> wr_ready low exactly 4 cycles. Then read 0x0000010 -> rd_valid in T+5 with the same 128-bit data.
- Read 0x0000A30 never written -> rd_data=0, rd_valid=1. Low address bits: read 0x000001C returns the line at 0x0000010.
- Same-cycle write 0x0000040=0xAA..AA and read 0x0000040 -> rd_data=0xAA..AA, rd_valid no earlier than write commit +1. Different index (0x0000050) -> read latency unchanged (T+5).
- rd_dready held low 6 cycles in R_RESP -> rd_valid and rd_data stable all 6 cycles. Handshake then drops rd_valid and raises rd_aready next cycle.
- rst=0 asserted 2 cycles after write acceptance to 0x0000020 -> wr_ready=1 after reset and a later read of 0x0000020 returns the old value. rd_valid=0 through reset.
- Aliasing with DEPTH_LOG2=12: write 0x0010000 (index 0) -> read 0x0000000 returns that data.
